// File: rtl/cnt_ctrl.sv
// Step-pulse controller: debounced RUN/PAUSE and STEP buttons drive a
// fixed-width strobe e that advances a downstream BCD counter.
module cnt_ctrl #(
  parameter int unsigned DIV    = 50000000,
  parameter int unsigned DB_CYC = 1000000,
  parameter int unsigned PW     = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_run,
  input  logic        btn_step,
  output logic        e,
  output logic        run,
  output logic [15:0] npulse
);

  localparam int unsigned PS_W = $clog2(DIV);
  localparam int unsigned PW_W = $clog2(PW + 1);
  localparam int unsigned DB_W = $clog2(DB_CYC);
  localparam int unsigned NBTN = 2;

  typedef enum logic {
    S_PAUSE = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  // Button index 0 is btn_run, index 1 is btn_step.
  logic [NBTN-1:0] sync1_q, sync2_q;
  logic [NBTN-1:0] lvl_q, lvl_d;
  logic [NBTN-1:0] press_q, press_d;
  logic [DB_W-1:0] db_cnt_q [NBTN];
  logic [DB_W-1:0] db_cnt_d [NBTN];

  state_e            state_q, state_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic [PW_W-1:0]   pw_cnt_q, pw_cnt_d;
  logic              e_q, e_d;
  logic              run_q, run_d;
  logic [15:0]       npulse_q, npulse_d;
  logic              pulse_req;

  // Debounce: level flips only after DB_CYC consecutive disagreeing cycles.
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      lvl_d[i]    = lvl_q[i];
      press_d[i]  = 1'b0;
      db_cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_CYC - 1)) begin
          lvl_d[i]   = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Next state, prescaler, pulse generation and status.
  always_comb begin
    state_d   = state_q;
    ps_d      = ps_q;
    pw_cnt_d  = pw_cnt_q;
    e_d       = e_q;
    npulse_d  = npulse_q;
    pulse_req = 1'b0;

    case (state_q)
      S_PAUSE: begin
        pulse_req = press_q[1];
        if (press_q[0]) begin
          state_d = S_RUN;
          ps_d    = '0;
        end
      end
      S_RUN: begin
        if (ps_q == PS_W'(DIV - 1)) begin
          ps_d      = '0;
          pulse_req = 1'b1;
        end else begin
          ps_d = ps_q + PS_W'(1);
        end
        if (press_q[0]) begin
          state_d = S_PAUSE;
        end
      end
      default: state_d = S_PAUSE;
    endcase

    // A running pulse always completes; requests during it are dropped.
    if (e_q) begin
      if (pw_cnt_q == PW_W'(PW)) begin
        e_d      = 1'b0;
        pw_cnt_d = '0;
      end else begin
        pw_cnt_d = pw_cnt_q + PW_W'(1);
      end
    end else if (pulse_req) begin
      e_d      = 1'b1;
      pw_cnt_d = PW_W'(1);
      npulse_d = npulse_q + 16'd1;
    end

    run_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      lvl_q       <= '0;
      press_q     <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      state_q     <= S_PAUSE;
      ps_q        <= '0;
      pw_cnt_q    <= '0;
      e_q         <= 1'b0;
      run_q       <= 1'b0;
      npulse_q    <= '0;
    end else begin
      sync1_q     <= {btn_step, btn_run};
      sync2_q     <= sync1_q;
      lvl_q       <= lvl_d;
      press_q     <= press_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      state_q     <= state_d;
      ps_q        <= ps_d;
      pw_cnt_q    <= pw_cnt_d;
      e_q         <= e_d;
      run_q       <= run_d;
      npulse_q    <= npulse_d;
    end
  end

  assign e      = e_q;
  assign run    = run_q;
  assign npulse = npulse_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Bench for cnt_ctrl with DIV=10, DB_CYC=4, PW=3; expected e rises are
// queued with their cycle and npulse value and matched by a negedge monitor.
module tb_cnt_ctrl;

  localparam int DIV    = 10;
  localparam int DB_CYC = 4;
  localparam int PW     = 3;
  // Cycles from driving a button high to the edge that acts on its press.
  localparam int LAT    = 2 + DB_CYC + 1;

  typedef struct {
    int cyc;
    int np;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        btn_run;
  logic        btn_step;
  logic        e;
  logic        run;
  logic [15:0] npulse;

  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  cnt_ctrl #(
    .DIV    (DIV),
    .DB_CYC (DB_CYC),
    .PW     (PW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .e        (e),
    .run      (run),
    .npulse   (npulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard consumer: every e rise must match the next queued entry.
  logic e_prev;
  int   hi;
  exp_t ex;
  always @(negedge clk) begin
    if (!rst_n) begin
      e_prev = 1'b0;
      hi     = 0;
    end else begin
      if (e && !e_prev) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_rise: e rose at cycle %0d, no pulse expected", cyc);
        end else begin
          ex = sb.pop_front();
          if (cyc !== ex.cyc) begin
            n_errors++;
            $display("FAIL rise_cycle: e rose at cycle %0d, expected %0d", cyc, ex.cyc);
          end
          n_checks++;
          if (npulse !== 16'(ex.np)) begin
            n_errors++;
            $display("FAIL rise_npulse: npulse=%0d, expected %0d", npulse, ex.np);
          end
        end
        hi = 1;
      end else if (e) begin
        hi++;
      end else if (e_prev) begin
        n_checks++;
        if (hi != PW) begin
          n_errors++;
          $display("FAIL pulse_width: e high %0d cycles, expected %0d", hi, PW);
        end
      end
      e_prev = e;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    btn_run  = 1'b0;
    btn_step = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    btn_run  = 1'b0;
    btn_step = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({e, run, npulse} !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_held: e=%b run=%b npulse=%0d, expected all 0", e, run, npulse);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({e, run, npulse} !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_idle: e=%b run=%b npulse=%0d, expected all 0", e, run, npulse);
    end
  endtask

  task automatic test_glitch();
    int k;
    do_reset();
    k = cyc;
    btn_run = 1'b1;
    wait_until(k + 3);
    btn_run = 1'b0;
    wait_until(k + 25);
    n_checks++;
    if ({e, run, npulse} !== 18'd0) begin
      n_errors++;
      $display("FAIL glitch_ignored: e=%b run=%b npulse=%0d, expected all 0", e, run, npulse);
    end
  endtask

  task automatic test_run_pause();
    int k;
    do_reset();
    k = cyc;
    btn_run = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back('{k + LAT + DIV * (i + 1), i + 1});
    wait_until(k + LAT - 1);
    n_checks++;
    if (run !== 1'b0) begin
      n_errors++;
      $display("FAIL run_early: run=%b at cycle %0d, expected 0", run, cyc - k);
    end
    wait_until(k + LAT);
    n_checks++;
    if (run !== 1'b1) begin
      n_errors++;
      $display("FAIL run_entry: run=%b at cycle %0d, expected 1", run, cyc - k);
    end
    wait_until(k + 10);
    btn_run = 1'b0;
    wait_until(k + 16);
    n_checks++;
    if (e !== 1'b0) begin
      n_errors++;
      $display("FAIL e_before_first: e=%b, expected 0", e);
    end
    // Pause so the toggle edge lands on the 2nd cycle of the 4th pulse (rise k+47).
    wait_until(k + 41);
    btn_run = 1'b1;
    wait_until(k + 48);
    n_checks++;
    if ({run, e} !== 2'b01) begin
      n_errors++;
      $display("FAIL pause_midpulse: run=%b e=%b, expected run=0 e=1", run, e);
    end
    wait_until(k + 49);
    n_checks++;
    if (e !== 1'b1) begin
      n_errors++;
      $display("FAIL pulse_not_truncated: e=%b, expected 1", e);
    end
    wait_until(k + 51);
    btn_run = 1'b0;
    wait_until(k + 85);
    n_checks++;
    if ({run, e, npulse} !== {2'b00, 16'd4} || sb.size() != 0) begin
      n_errors++;
      $display("FAIL run_pause_end: run=%b e=%b npulse=%0d pending=%0d, expected 0 0 4 0",
               run, e, npulse, sb.size());
    end
  endtask

  task automatic test_step();
    int s;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      s = cyc;
      btn_step = 1'b1;
      sb.push_back('{s + LAT, p + 1});
      wait_until(s + 6);
      btn_step = 1'b0;
      wait_until(s + 20);
    end
    n_checks++;
    if ({run, e, npulse} !== {2'b00, 16'd2} || sb.size() != 0) begin
      n_errors++;
      $display("FAIL step_end: run=%b e=%b npulse=%0d pending=%0d, expected 0 0 2 0",
               run, e, npulse, sb.size());
    end
  endtask

  task automatic test_drop();
    int k;
    do_reset();
    k = cyc;
    btn_run = 1'b1;
    sb.push_back('{k + LAT + DIV, 1});
    sb.push_back('{k + LAT + 2 * DIV, 2});
    wait_until(k + 10);
    btn_run = 1'b0;
    // Pause at k+28 (2nd pulse rises k+27); step strobe lands at k+29 while e high.
    wait_until(k + 21);
    btn_run = 1'b1;
    wait_until(k + 22);
    btn_step = 1'b1;
    wait_until(k + 29);
    n_checks++;
    if ({run, e} !== 2'b01) begin
      n_errors++;
      $display("FAIL drop_window: run=%b e=%b, expected run=0 e=1", run, e);
    end
    wait_until(k + 32);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    wait_until(k + 60);
    n_checks++;
    if ({run, e, npulse} !== {2'b00, 16'd2} || sb.size() != 0) begin
      n_errors++;
      $display("FAIL drop_end: run=%b e=%b npulse=%0d pending=%0d, expected 0 0 2 0",
               run, e, npulse, sb.size());
    end
  endtask

  task automatic test_simultaneous();
    int d;
    do_reset();
    d = cyc;
    btn_run  = 1'b1;
    btn_step = 1'b1;
    sb.push_back('{d + LAT, 1});
    for (int i = 0; i < 5; i++) sb.push_back('{d + LAT + DIV * (i + 1), i + 2});
    wait_until(d + LAT);
    n_checks++;
    if ({run, e} !== 2'b11) begin
      n_errors++;
      $display("FAIL both_press: run=%b e=%b, expected 1 1", run, e);
    end
    wait_until(d + 10);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    // Step in RUN would rise at d+42, clear of the prescaler pulses.
    wait_until(d + 35);
    btn_step = 1'b1;
    wait_until(d + 45);
    btn_step = 1'b0;
    wait_until(d + 53);
    btn_run = 1'b1;
    wait_until(d + 63);
    btn_run = 1'b0;
    wait_until(d + 95);
    n_checks++;
    if ({run, e, npulse} !== {2'b00, 16'd6} || sb.size() != 0) begin
      n_errors++;
      $display("FAIL simul_end: run=%b e=%b npulse=%0d pending=%0d, expected 0 0 6 0",
               run, e, npulse, sb.size());
    end
  endtask

  task automatic test_async_reset();
    int k;
    do_reset();
    k = cyc;
    btn_run = 1'b1;
    for (int i = 0; i < 5; i++) sb.push_back('{k + LAT + DIV * (i + 1), i + 1});
    wait_until(k + 10);
    btn_run = 1'b0;
    wait_until(k + LAT + 5 * DIV);
    n_checks++;
    if ({run, e, npulse} !== {2'b11, 16'd5}) begin
      n_errors++;
      $display("FAIL pre_reset: run=%b e=%b npulse=%0d, expected 1 1 5", run, e, npulse);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({run, e, npulse} !== 18'd0) begin
      n_errors++;
      $display("FAIL async_reset: run=%b e=%b npulse=%0d, expected all 0", run, e, npulse);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = cyc;
    wait_until(k + 40);
    n_checks++;
    if ({run, e, npulse} !== 18'd0 || sb.size() != 0) begin
      n_errors++;
      $display("FAIL post_reset: run=%b e=%b npulse=%0d pending=%0d, expected all 0",
               run, e, npulse, sb.size());
    end
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    btn_run  = 1'b0;
    btn_step = 1'b0;
    test_reset();
    test_glitch();
    test_run_pause();
    test_step();
    test_drop();
    test_simultaneous();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
